// File: rtl/rb_on_g_reconstruct.sv
// Purpose : rebuild R and B at Bayer G sites from upstream (G-R)/(G-B) neighbour-sum differences.
// Latency : 2 cycles from input transfer to o_valid, 1 pixel/clk sustained.
// Backpr. : valid/ready both ends; o_ready = ~s1_valid | s2_ready, outputs hold while o_valid & ~i_ready.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_valid/o_ready                 input handshake; i_sof marks pixel (0,0)
//   i_g_c                           centre pixel value (W bits)
//   i_gr_h/i_gr_v/i_gb_h/i_gb_v     signed W+2 colour-difference sums
//   o_valid/i_ready                 output handshake
//   o_g/o_r/o_b                     centre G, reconstructed R/B (0 at non-G sites)
//   o_is_g/o_sof/o_eof              site and frame tags
//
// Build option: define RB_ON_G_ROUND_EN for round-half-up halving of the
// difference sums; otherwise the halving is a plain floor (arithmetic shift).
module rb_on_g_reconstruct #(
    parameter int pixelBitWidth = 12,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int BAYER_PATTERN = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_sof,
    input  logic [pixelBitWidth-1:0]        i_g_c,
    input  logic signed [pixelBitWidth+1:0] i_gr_h,
    input  logic signed [pixelBitWidth+1:0] i_gr_v,
    input  logic signed [pixelBitWidth+1:0] i_gb_h,
    input  logic signed [pixelBitWidth+1:0] i_gb_v,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [pixelBitWidth-1:0]        o_g,
    output logic [pixelBitWidth-1:0]        o_r,
    output logic [pixelBitWidth-1:0]        o_b,
    output logic                            o_is_g,
    output logic                            o_sof,
    output logic                            o_eof
);

    localparam int W  = pixelBitWidth;
    localparam int DW = W + 2;            // difference-sum width
    localparam int XW = W + 3;            // working width: no intermediate can wrap
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_in_xfer;
    logic          w_s2_ready;
    logic [1:0]    w_phase;
    logic          w_is_g;
    logic          w_red_row;

    // i_sof overrides the counters so a frame can be resynchronised anywhere.
    assign w_col      = i_sof ? '0 : r_col;
    assign w_row      = i_sof ? '0 : r_row;
    assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
    assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));

    assign w_s2_ready = ~o_valid | i_ready;
    assign o_ready    = ~r_s1_valid | w_s2_ready;
    assign w_in_xfer  = i_valid & o_ready;

    // Phase 1 = G on a red row, 2 = G on a blue row, 0/3 = R/B sites.
    assign w_phase   = 2'(BAYER_PATTERN) ^ {w_row[0], w_col[0]};
    assign w_is_g    = (w_phase == 2'd1) || (w_phase == 2'd2);
    assign w_red_row = (w_phase == 2'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_xfer) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture centre value, tags and the sums relevant to the site
    // ------------------------------------------------------------------
    logic                 r_s1_valid;
    logic [W-1:0]         r_s1_g;
    logic signed [DW-1:0] r_s1_dr;
    logic signed [DW-1:0] r_s1_db;
    logic                 r_s1_is_g;
    logic                 r_s1_sof;
    logic                 r_s1_eof;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
            r_s1_dr    <= '0;
            r_s1_db    <= '0;
            r_s1_is_g  <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else begin
            if (o_ready) begin
                r_s1_valid <= i_valid;
            end
            if (w_in_xfer) begin
                r_s1_g    <= i_g_c;
                // Red row: R neighbours are left/right, B neighbours above/below.
                r_s1_dr   <= w_red_row ? i_gr_h : i_gr_v;
                r_s1_db   <= w_red_row ? i_gb_v : i_gb_h;
                r_s1_is_g <= w_is_g;
                r_s1_sof  <= (w_col == '0) && (w_row == '0);
                r_s1_eof  <= w_last_col && w_last_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: halve the difference, subtract from G, saturate to [0, 2^W-1]
    // ------------------------------------------------------------------
    function automatic logic signed [XW-1:0] half_diff(input logic signed [DW-1:0] d);
        logic signed [XW-1:0] ext;
        logic signed [XW-1:0] one;
        one = {{(XW-1){1'b0}}, 1'b1};
        ext = {d[DW-1], d};
`ifdef RB_ON_G_ROUND_EN
        // Round half up; the extra bit keeps (max+1) from wrapping.
        return (ext + one) >>> 1;
`else
        one = '0;
        return (ext + one) >>> 1;
`endif
    endfunction

    function automatic logic [W-1:0] rebuild(input logic [W-1:0] g, input logic signed [DW-1:0] d);
        logic signed [XW-1:0] raw;
        raw = $signed({3'b000, g}) - half_diff(d);
        if (raw[XW-1]) begin
            return '0;
        end else if (|raw[XW-2:W]) begin
            return '1;
        end else begin
            return raw[W-1:0];
        end
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_g     <= '0;
            o_r     <= '0;
            o_b     <= '0;
            o_is_g  <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
        end else if (w_s2_ready) begin
            o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_g    <= r_s1_g;
                o_r    <= r_s1_is_g ? rebuild(r_s1_g, r_s1_dr) : '0;
                o_b    <= r_s1_is_g ? rebuild(r_s1_g, r_s1_db) : '0;
                o_is_g <= r_s1_is_g;
                o_sof  <= r_s1_sof;
                o_eof  <= r_s1_eof;
            end
        end
    end

endmodule

// File: tb/tb_rb_on_g_reconstruct.sv
// Purpose : self-checking bench for rb_on_g_reconstruct (W=12, 8x4 image, RGGB).
// Latency : n/a (bench).
// Backpr. : drives random and patterned i_ready to exercise stalls.
module tb_rb_on_g_reconstruct;

    localparam int W  = 12;
    localparam int D  = 14;
    localparam int IW = 8;
    localparam int IH = 4;
    localparam int BP = 0;
    localparam int MAXV = 4095;
`ifdef RB_ON_G_ROUND_EN
    localparam int T3_R = 501;
`else
    localparam int T3_R = 502;
`endif

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_valid;
    logic                o_ready;
    logic                i_sof;
    logic [W-1:0]        i_g_c;
    logic signed [D-1:0] i_gr_h, i_gr_v, i_gb_h, i_gb_v;
    logic                o_valid;
    logic                i_ready;
    logic [W-1:0]        o_g, o_r, o_b;
    logic                o_is_g, o_sof, o_eof;

    always #5 i_clk = ~i_clk;

    rb_on_g_reconstruct #(
        .pixelBitWidth(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .BAYER_PATTERN(BP)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_sof(i_sof), .i_g_c(i_g_c),
        .i_gr_h(i_gr_h), .i_gr_v(i_gr_v), .i_gb_h(i_gb_h), .i_gb_v(i_gb_v),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_g(o_g), .o_r(o_r), .o_b(o_b),
        .o_is_g(o_is_g), .o_sof(o_sof), .o_eof(o_eof)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int g;
        int r;
        int b;
        bit is_g;
        bit sof;
        bit eof;
    } exp_t;

    exp_t q[$];
    int   m_col = 0, m_row = 0;
    int   inflight = 0;
    int   n_out = 0, n_acc = 0, n_eof = 0;
    int   last_r, last_b;
    bit   last_sof, last_is_g;

    // Colour of a site from the CFA layout tables.
    function automatic byte site_colour(input int row, input int col);
        string tbl[4];
        string s;
        tbl = '{"RGGB", "GRBG", "GBRG", "BGGR"};
        s = tbl[BP];
        return s[(row % 2) * 2 + (col % 2)];
    endfunction

    function automatic bit row_has_red(input int row);
        return site_colour(row, 0) == "R" || site_colour(row, 1) == "R";
    endfunction

    function automatic int floor_half(input int x);
        return (x >= 0) ? x / 2 : -((1 - x) / 2);
    endfunction

    function automatic int half(input int d);
`ifdef RB_ON_G_ROUND_EN
        return floor_half(d + 1);
`else
        return floor_half(d);
`endif
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : (v > MAXV) ? MAXV : v;
    endfunction

    function automatic int rsum();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    // One clock: drive inputs, check everything observable, update the model.
    task automatic step(input bit vld, input bit sof, input int g, input int grh, input int grv,
                        input int gbh, input int gbv, input bit ordy);
        exp_t e;
        int   pr, pc, dr, db;
        bit   acc;
        i_valid = vld; i_sof = sof; i_g_c = 12'(g);
        i_gr_h = 14'(grh); i_gr_v = 14'(grv); i_gb_h = 14'(gbh); i_gb_v = 14'(gbv);
        i_ready = ordy;
        #1;
        chk("in_ready", 32'(o_ready), (inflight == 2 && !ordy) ? 32'd0 : 32'd1);
        acc = vld && o_ready;
        if (inflight == 0) chk("idle_out_valid", 32'(o_valid), 0);
        if (inflight == 2) chk("full_out_valid", 32'(o_valid), 1);
        if (o_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(q.size()), 1);
            end else begin
                e = q[0];
                chk("out_g", 32'(o_g), e.g);
                chk("out_r", 32'(o_r), e.r);
                chk("out_b", 32'(o_b), e.b);
                chk("out_is_g", 32'(o_is_g), 32'(e.is_g));
                chk("out_sof", 32'(o_sof), 32'(e.sof));
                chk("out_eof", 32'(o_eof), 32'(e.eof));
                if (ordy) begin
                    void'(q.pop_front());
                    inflight--;
                    n_out++;
                    if (o_eof) n_eof++;
                    last_r = o_r; last_b = o_b; last_sof = o_sof; last_is_g = o_is_g;
                end
            end
        end
        if (acc) begin
            pc = sof ? 0 : m_col;
            pr = sof ? 0 : m_row;
            e.g    = g & MAXV;
            e.is_g = site_colour(pr, pc) == "G";
            e.sof  = (pc == 0 && pr == 0);
            e.eof  = (pc == IW - 1 && pr == IH - 1);
            dr = row_has_red(pr) ? grh : grv;
            db = row_has_red(pr) ? gbv : gbh;
            e.r = e.is_g ? sat(e.g - half(dr)) : 0;
            e.b = e.is_g ? sat(e.g - half(db)) : 0;
            q.push_back(e);
            inflight++;
            n_acc++;
            pc++;
            if (pc == IW) begin
                pc = 0;
                pr = (pr + 1) % IH;
            end
            m_col = pc;
            m_row = pr;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic rnd_px(input bit sof, input bit ordy);
        step(1'b1, sof, int'($urandom_range(0, 4095)), rsum(), rsum(), rsum(), rsum(), ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (inflight > 0) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        end
        chk("drain_empty", 32'(inflight), 0);
    endtask

    task automatic do_reset();
        i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b1;
        i_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(o_valid), 0);
        chk("rst_in_ready", 32'(o_ready), 1);
        chk("rst_out_data", {o_g, o_r, o_b}, 0);
        chk("rst_out_tags", {o_is_g, o_sof, o_eof}, 0);
        @(posedge i_clk);
        #1;
        chk("rst_hold_valid", 32'(o_valid), 0);
        i_rst_n = 1'b1;
        q.delete();
        inflight = 0;
        m_col = 0;
        m_row = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc0, out0, eof0, k;
        logic [3:0] rpat;
        i_rst_n = 1'b0;
        i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b1; i_g_c = '0;
        i_gr_h = '0; i_gr_v = '0; i_gb_h = '0; i_gb_v = '0;
        #2;
        do_reset();

        // 1: G on red row, two-cycle latency
        rnd_px(1'b1, 1'b1);
        chk("lat_after_1clk", 32'(o_valid), 0);
        step(1'b1, 1'b0, 2000, 400, 0, 0, -600, 1'b1);
        chk("lat_after_2clk", 32'(o_valid), 1);
        drain();
        chk("t1_r", last_r, 1800);
        chk("t1_b", last_b, 2300);

        // 2: site (1,0), both clamps (gb_h is the most negative-ish sum in range)
        for (int i = 0; i < 6; i++) rnd_px(1'b0, 1'b1);
        step(1'b1, 1'b0, 100, 0, 1000, -8000, 0, 1'b1);
        drain();
        chk("t2_r_clamp_low", last_r, 0);
        chk("t2_b_clamp_high", last_b, MAXV);

        // 3: negative odd difference at red-row G (2,1)
        for (int i = 0; i < 8; i++) rnd_px(1'b0, 1'b1);
        step(1'b1, 1'b0, 500, -3, 0, 0, 0, 1'b1);
        drain();
        chk("t3_r_halving", last_r, T3_R);

        // 4: full frame with out_ready pattern 1,0,0,1
        rpat = 4'b1001;
        acc0 = n_acc; out0 = n_out; eof0 = n_eof; k = 0;
        while (n_acc - acc0 < IW * IH && k < 400) begin
            rnd_px(n_acc == acc0, rpat[k % 4]);
            k++;
        end
        drain();
        chk("t4_outputs", 32'(n_out - out0), IW * IH);
        chk("t4_eof_count", 32'(n_eof - eof0), 1);

        // 5: reset mid-frame after pixel 13, then a fresh frame
        acc0 = n_acc; k = 0;
        while (n_acc - acc0 < 14 && k < 200) begin
            rnd_px(n_acc == acc0, $urandom_range(0, 9) < 7);
            k++;
        end
        do_reset();
        for (int i = 0; i < 12; i++) rnd_px(i == 0, $urandom_range(0, 9) < 7);
        drain();

        // 6: in_sof re-asserted at pixel 5
        for (int i = 0; i < 5; i++) rnd_px(i == 0, 1'b1);
        rnd_px(1'b1, 1'b1);
        drain();
        chk("t6_sof", 32'(last_sof), 1);
        chk("t6_is_g", 32'(last_is_g), 0);
        chk("t6_rb_zero", 32'(last_r + last_b), 0);

        // random traffic
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) != 0)
                rnd_px($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
            else
                step(1'b0, 1'b0, 0, 0, 0, 0, 0, $urandom_range(0, 9) < 7);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
